// File: rtl/tts_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM states, table and
// settle-counter widths.
package tts_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDrive  = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } tts_state_e;

  localparam int unsigned N_DEFAULT    = 3;
  localparam int unsigned TABLE_W      = 1 << N_DEFAULT;
  localparam int unsigned SETTLE_CNT_W = 4;

  function automatic int unsigned table_width(input int unsigned n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Stimulus/capture bundle between the sweeper and the environment that owns the
// mux network under test.
interface truth_table_sweeper_if #(
  parameter int unsigned N  = tts_pkg::N_DEFAULT,
  parameter int unsigned TW = tts_pkg::table_width(N)
);
  logic          start;
  logic          f_in;
  logic [TW-1:0] expected;
  logic [N-1:0]  pattern;
  logic          busy;
  logic          done;
  logic [TW-1:0] table_out;
  logic          table_valid;
  logic          match;

  modport master (
    output start, f_in, expected,
    input  pattern, busy, done, table_out, table_valid, match
  );

  modport slave (
    input  start, f_in, expected,
    output pattern, busy, done, table_out, table_valid, match
  );
endinterface

// File: rtl/tts_settle_counter.sv
// Loadable settle counter; term_o flags the last DRIVE cycle of a pattern.
module tts_settle_counter
  import tts_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic                    load_i,
  input  logic [SETTLE_CNT_W-1:0] load_val_i,
  output logic                    term_o
);

  logic [SETTLE_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign term_o = (cnt_q == SETTLE_CNT_W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input combination through a mux network and captures the returned
// bits as a truth table, compared against an expected table on completion.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int unsigned N      = N_DEFAULT,
  parameter int unsigned SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  truth_table_sweeper_if.slave  bus
);

  localparam int unsigned TW = table_width(N);

  tts_state_e    state_q;
  logic [N-1:0]  pattern_q;
  logic          busy_q;
  logic          done_q;
  logic          valid_q;
  logic          match_q;
  logic [TW-1:0] shadow_q;
  logic [TW-1:0] table_q;
  logic [TW-1:0] shadow_d;
  logic          last_pat;
  logic          cnt_clr;
  logic          cnt_en;
  logic          cnt_term;

  assign last_pat = &pattern_q;

  always_comb begin
    shadow_d           = shadow_q;
    shadow_d[pattern_q] = bus.f_in;
  end

  always_comb begin
    cnt_clr = ((state_q == StIdle) && bus.start) || ((state_q == StSample) && !last_pat);
    cnt_en  = (state_q == StDrive);
  end

  tts_settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk_i      (clk),
    .rst_i      (reset),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .load_i     (1'b0),
    .load_val_i ('0),
    .term_o     (cnt_term)
  );

  // Result registers move only on the SAMPLE->DONE edge so the new table,
  // match and done appear together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pattern_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      match_q   <= 1'b0;
      shadow_q  <= '0;
      table_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q   <= StDrive;
            pattern_q <= '0;
            shadow_q  <= '0;
            busy_q    <= 1'b1;
          end
        end
        StDrive: begin
          if (cnt_term) begin
            state_q <= StSample;
          end
        end
        StSample: begin
          shadow_q <= shadow_d;
          if (!last_pat) begin
            pattern_q <= pattern_q + 1'b1;
            state_q   <= StDrive;
          end else begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            table_q <= shadow_d;
            match_q <= (shadow_d == bus.expected);
            valid_q <= 1'b1;
          end
        end
        StDone: begin
          pattern_q <= '0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pattern     = pattern_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.table_out   = table_q;
  assign bus.table_valid = valid_q;
  assign bus.match       = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a SETTLE=1 and a SETTLE=3 instance checked
// against a cycle/table model derived from the sweep rules.
module tb_truth_table_sweeper;

  localparam int unsigned SA    = 1;
  localparam int unsigned SB    = 3;
  localparam int          NCOMB = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N(3)) bus_a ();
  truth_table_sweeper_if #(.N(3)) bus_b ();

  truth_table_sweeper #(.N(3), .SETTLE(SA)) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  truth_table_sweeper #(.N(3), .SETTLE(SB)) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  logic [7:0] ftab_a;
  logic       noise_a;
  logic [7:0] model_tab_a;

  always_comb bus_a.f_in = ftab_a[bus_a.pattern] ^ noise_a;
  always_comb bus_b.f_in = bus_b.pattern[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One SETTLE=1 sweep on instance A; cycle j counts from the cycle after the
  // edge that samples start.
  task automatic run_a(input logic [7:0] ftab, input logic [7:0] exp, input int ign1,
                       input int ign2, input bit glitch);
    int ndone;
    int dcyc;
    int sweep_len;
    sweep_len = NCOMB * (SA + 1);
    ftab_a = ftab;
    bus_a.expected = 8'($urandom);
    @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    ndone = 0;
    dcyc  = 0;
    for (int j = 1; j <= 30; j++) begin
      if (j <= sweep_len) begin
        check_eq("pattern", 32'(bus_a.pattern), 32'((j - 1) / (SA + 1)));
        check_eq("busy", 32'(bus_a.busy), 32'd1);
      end
      if (j == sweep_len) check_eq("table_hold", 32'(bus_a.table_out), 32'(model_tab_a));
      if (bus_a.done) begin
        ndone++;
        if (dcyc == 0) dcyc = j;
      end
      // Toggle f_in only in DRIVE cycles; SAMPLE cycles see the clean function.
      noise_a = (glitch && j <= sweep_len && ((j - 1) % (SA + 1)) < SA) ? 1'($urandom) : 1'b0;
      bus_a.start = (j == ign1) || (j == ign2);
      bus_a.expected = (j == sweep_len) ? exp : 8'($urandom);
      @(negedge clk);
    end
    noise_a = 1'b0;
    bus_a.start = 1'b0;
    model_tab_a = ftab;
    check_eq("done_count", 32'(ndone), 32'd1);
    check_eq("done_cycle", 32'(dcyc), 32'(sweep_len + 1));
    check_eq("table_out", 32'(bus_a.table_out), 32'(ftab));
    check_eq("match", 32'(bus_a.match), 32'(ftab == exp));
    check_eq("table_valid", 32'(bus_a.table_valid), 32'd1);
  endtask

  initial begin
    int d1;
    int d2;
    int nd;
    logic [7:0] ft;
    logic [7:0] ex;

    reset = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    bus_a.expected = '0;
    bus_b.expected = '0;
    ftab_a = '0;
    noise_a = 1'b0;
    model_tab_a = '0;
    #12;
    check_eq("rst_pattern", 32'(bus_a.pattern), 32'd0);
    check_eq("rst_busy", 32'(bus_a.busy), 32'd0);
    check_eq("rst_done", 32'(bus_a.done), 32'd0);
    check_eq("rst_table", 32'(bus_a.table_out), 32'd0);
    check_eq("rst_valid", 32'(bus_a.table_valid), 32'd0);
    check_eq("rst_match", 32'(bus_a.match), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Majority function, then constant-0 with matching and mismatching expected.
    run_a(8'hE8, 8'hE8, 0, 0, 1'b0);
    run_a(8'h00, 8'h00, 0, 0, 1'b0);
    run_a(8'h00, 8'h01, 0, 0, 1'b0);
    // f = c with start retried while busy, and DRIVE-phase glitches on f_in.
    run_a(8'hAA, 8'hAA, 5, 10, 1'b1);
    run_a(8'hE8, 8'hE8, 0, 0, 1'b1);

    // Asynchronous reset in cycle 9 of a sweep.
    @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_pattern", 32'(bus_a.pattern), 32'd0);
    check_eq("arst_busy", 32'(bus_a.busy), 32'd0);
    check_eq("arst_table", 32'(bus_a.table_out), 32'd0);
    check_eq("arst_valid", 32'(bus_a.table_valid), 32'd0);
    check_eq("arst_match", 32'(bus_a.match), 32'd0);
    model_tab_a = '0;
    @(negedge clk);
    reset = 1'b0;
    run_a(8'hE8, 8'hE8, 0, 0, 1'b0);

    // Randomized functions and expected tables.
    for (int r = 0; r < 6; r++) begin
      ft = 8'($urandom);
      ex = ($urandom_range(0, 1) == 1) ? ft : 8'($urandom);
      run_a(ft, ex, $urandom_range(1, 17), $urandom_range(1, 17), 1'b1);
    end

    // start held high: back-to-back sweeps with one IDLE cycle between.
    ftab_a = 8'hFF;
    bus_a.expected = 8'hFF;
    @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    d1 = 0;
    d2 = 0;
    nd = 0;
    for (int j = 1; j <= 40; j++) begin
      if (bus_a.done) begin
        nd++;
        if (nd == 1) d1 = j;
        else if (nd == 2) d2 = j;
      end
      if (j == 17 || j == 35) check_eq("held_table", 32'(bus_a.table_out), 32'hFF);
      if (j == 18) check_eq("held_idle_busy", 32'(bus_a.busy), 32'd0);
      if (j == 19) check_eq("held_restart_busy", 32'(bus_a.busy), 32'd1);
      if (j == 36) bus_a.start = 1'b0;
      @(negedge clk);
    end
    check_eq("held_done_count", 32'(nd), 32'd2);
    check_eq("held_done1", 32'(d1), 32'd17);
    check_eq("held_done2", 32'(d2), 32'd35);
    check_eq("held_idle_after", 32'(bus_a.busy), 32'd0);

    // SETTLE=3 instance with f = t.
    bus_b.expected = 8'hF0;
    @(negedge clk);
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    d1 = 0;
    for (int j = 1; j <= 60; j++) begin
      if (j == 5) check_eq("b_pattern_j5", 32'(bus_b.pattern), 32'd1);
      if (bus_b.done && d1 == 0) d1 = j;
      @(negedge clk);
    end
    check_eq("b_done_cycle", 32'(d1), 32'(NCOMB * (SB + 1) + 1));
    check_eq("b_table", 32'(bus_b.table_out), 32'hF0);
    check_eq("b_match", 32'(bus_b.match), 32'd1);
    check_eq("b_valid", 32'(bus_b.table_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus and capture stage wrapped around the combinational mux-implemented logic functions (mux2/mux4 variants).
- Upstream role: drives every input combination, in ascending binary order, onto the function's data/select inputs.
- Downstream role: samples the function output for each combination and assembles a 2^N-bit truth table (bit i = f(i)).
- Compares the table against an expected value so mux wiring can be checked on-chip without a $monitor sweep.

Parameters:
- N, 3, number of function inputs; pattern width.
- SETTLE, 1, cycles the pattern is held before sampling; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- start  input  1  begins a sweep when sampled high in IDLE.
- f_in  input  1  function output returned from the mux network under test.
- expected  input  2^N  reference truth table; sampled at the DONE transition.
- pattern  output  N  current input combination driven to the mux network (MSB = select/t).
- busy  output  1  high in DRIVE and SAMPLE.
- done  output  1  one-cycle pulse when a sweep completes.
- table_out  output  2^N  last completed truth table; held until the next completion.
- table_valid  output  1  set at first completion; cleared only by reset.
- match  output  1  (table_out == expected) latched at completion; valid when table_valid = 1.

Behaviour:
- Reset values: all outputs 0; state IDLE; settle counter 0; shadow table 0.
- Reset asserted mid-sweep aborts immediately:
  - Partial shadow table discarded.
  - table_out, table_valid and match return to 0.
- States:
  - IDLE: pattern = 0. On start = 1 → DRIVE; pattern = 0, settle counter = 0, shadow table = 0.
  - DRIVE: pattern held. Counter increments each cycle; after SETTLE cycles in DRIVE → SAMPLE.
  - SAMPLE (one cycle):
    - Shadow table bit [pattern] <= f_in.
    - If pattern != 2^N-1: pattern <= pattern+1, counter <= 0, → DRIVE.
    - Else → DONE.
  - DONE (one cycle):
    - done = 1.
    - table_out <= shadow with the final bit included.
    - match <= (that value == expected).
    - table_valid <= 1.
    - pattern <= 0; → IDLE.
- Timing: with start sampled at edge k and SETTLE = S:
  - DRIVE for pattern p occupies cycles k+1+p*(S+1) .. k+p*(S+1)+S.
  - Sweep length is 2^N*(S+1) cycles.
  - done is high in cycle k+2^N*(S+1)+1.
  - N=3, S=1: done in cycle k+17.
- Boundaries and simultaneous events:
  - start while busy or in DONE: ignored, no restart.
  - start held high continuously: a new sweep begins on the first IDLE cycle after DONE (back-to-back, one IDLE cycle between sweeps).
  - pattern wrap: never increments past 2^N-1; it returns to 0 only via DONE.
  - f_in is sampled only in SAMPLE; glitches during DRIVE have no effect.
  - expected may change at any time; only its value at the DONE transition matters.
  - table_out is never partially updated; a new table appears atomically at done.

Decomposition:
- Shared package tts_pkg:
  - state enum (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3).
  - localparam TABLE_W = 2^N.
  - settle counter width constant (4 bits).
- One natural sub-module, tts_settle_counter:
  - loadable 4-bit counter with clear and a terminal flag (count == SETTLE-1).
  - used by DRIVE.
- All other logic is inline in truth_table_sweeper.

Test Plan:
- Majority function (f = ab+ac+bc via mux4), N=3, S=1, expected = 8'hE8, start pulse at cycle 0 -> pattern steps 0..7 every 2 cycles; done pulses at cycle 17; table_out = 8'hE8; match = 1; table_valid = 1.
- f_in tied 0, expected = 8'h00 -> table_out = 8'h00, match = 1; rerun with expected = 8'h01 -> match = 0, table_out still 8'h00.
- f_in = pattern[0] (mux2 passing c) -> table_out = 8'hAA; pulse start again at cycles 5 and 10 -> ignored, single done at cycle 17.
- Assert reset asynchronously mid-cycle at cycle 9 of a sweep following a completed 8'hE8 sweep -> outputs 0 immediately, table_valid = 0; release and start -> fresh sweep, done 17 cycles after start.
- SETTLE = 3, f_in = pattern[2] -> 4 cycles per combination; done at cycle 33; table_out = 8'hF0.
- start held high for 40 cycles, f_in = 1 -> done at cycles 17 and 35; table_out = 8'hFF each time; exactly one IDLE cycle between sweeps.
